matrix_link_rx: RTL and testbench
=================================

// Module: matrix_link_rx
// PURPOSE
//  Receive end of the matrix serial link: deserializes frames driven by the matrix
//  transmitter (cell/row/column/full-matrix sends) and stores each payload byte into a
//  ROWS x COLS receive matrix. Sits beside the transmit matrix inside main; drives r_cell/r_busy.
//  Frame (LSB first): start(0) | row | col[1:0] | data[7:0] | even parity over addr+data | stop(1).
// PARAMETERS
//  CLKS_PER_BIT  16  clocks per serial bit; must be even and >= 4
//  DATA_W        8   payload width
//  ROWS          2   matrix rows (row address 1 bit)
//  COLS          4   matrix columns (col address 2 bits)
// PORTS
//  clk        in   1       single system clock, rising edge
//  rst        in   1       asynchronous, active-low reset
//  rx         in   1       serial line, idles high, asynchronous to clk
//  rd_row     in   1       read-select row
//  rd_col     in   2       read-select column
//  r_cell     out  DATA_W  matrix[rd_row][rd_col], combinational read of registered array
//  r_busy     out  1       high from confirmed start bit to stop-bit sample
//  r_valid    out  1       1-cycle pulse: good frame written
//  r_err      out  1       1-cycle pulse: parity or stop-bit error, frame discarded
//  r_addr     out  3       {row,col} of last good frame
//  frame_cnt  out  8       good frames since reset, wraps 255->0
//  err_cnt    out  8       bad frames since reset, saturates at 255
// BEHAVIOUR
//  - Reset (rst=0, async): all matrix cells 0, all outputs 0, FSM IDLE, rx sync regs = 1.
//  - rx through 2-FF synchronizer; start = falling edge of synced rx while IDLE.
//  - FSM IDLE->START: wait CLKS_PER_BIT/2 clocks, resample; low -> ADDR (r_busy=1),
//    high -> IDLE (glitch, no flags, no count).
//  - ADDR (3 bits), DATA (DATA_W bits), PARITY (1), STOP (1): each bit sampled once,
//    CLKS_PER_BIT clocks after the previous sample (mid-bit).
//  - At stop sample: stop=1 and parity even -> matrix[row][col]<=data, r_addr<=addr,
//    r_valid=1, frame_cnt+1. Else r_err=1, err_cnt+1 (sat), matrix untouched.
//  - Write/flags/counters register on the clock edge after the stop sample; r_busy drops
//    that same edge; FSM returns to IDLE immediately (half a bit early) so back-to-back
//    frames with no idle gap are accepted.
//  - r_valid and r_err never both high. Read of a cell being written: old value up to the
//    write edge, new value after.
//  - Line held low (break): frame error at stop; no new start until rx seen high then
//    falling again.
//  - rst asserted mid-frame: frame abandoned, matrix cleared, no flags.
//  - Bit timer counts 0..CLKS_PER_BIT-1, reloads on each sample; bit index counts 0..DATA_W-1.
// STRUCTURE
//  - Shared package matrix_link_pkg: frame field widths/order, ADDR_W=3, parity type (even),
//    FSM state enum {IDLE,START,ADDR,DATA,PARITY,STOP}, default CLKS_PER_BIT; the transmitter
//    imports the same package.
//  - Sub-module mlink_bit_timer: 2-FF rx sync, falling-edge detect, half/full-bit tick gen.
//  - Top: FSM, shift register, parity accumulator, matrix array, counters.
// TESTING (CLKS_PER_BIT=16, idle >= 2 bits between scenarios unless stated)
//  1 frame row0 col1 data 0x22 -> r_valid pulse once, r_addr=3'b001, read (0,1)=0x22,
//    other cells 0x00, frame_cnt=1.
//  2 frame row0 col2 data 0x33, parity bit flipped -> r_err pulse, (0,2) stays 0x00,
//    err_cnt=1, frame_cnt unchanged.
//  3 8 back-to-back frames (no gap) row-major 0x11..0x88 -> 8 r_valid pulses,
//    (0,0)=0x11 ... (1,3)=0x88, r_busy high throughout each frame.
//  4 rx low for 3 clocks then high -> r_busy never asserts, no pulses, counters unchanged.
//  5 stop bit driven 0 on frame (1,0) data 0x55 -> r_err, cell unchanged; rx held low
//    5 bit times -> no further frame until rx high then start.
//  6 rst=0 during DATA bit 4 -> r_busy=0, all cells 0x00, counters 0; next valid frame
//    (1,3) 0xA5 received correctly.

Source files
------------

// File: rtl/matrix_link_pkg.sv
// Shared definitions for the matrix serial link (transmitter and receiver).
// Frame on the wire, LSB first:
//   start(0) | row | col[1:0] | data[DATA_W-1:0] | even parity over addr+data | stop(1)
package matrix_link_pkg;

  localparam int unsigned CLKS_PER_BIT_DEF = 16;
  localparam int unsigned DATA_W_DEF       = 8;
  localparam int unsigned ROWS_DEF         = 2;
  localparam int unsigned COLS_DEF         = 4;
  localparam int unsigned ROW_W            = 1;
  localparam int unsigned COL_W            = 2;
  localparam int unsigned ADDR_W           = ROW_W + COL_W;

  // XOR of addr, data and parity bit for a clean frame (even parity).
  localparam logic PARITY_RESIDUE = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    START,
    ADDR,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  // Address field as it lands in an LSB-first shift register: row arrives first.
  typedef struct packed {
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
  } addr_field_t;

  // Reported address order is {row, col}.
  function automatic logic [ADDR_W-1:0] addr_to_rc(input addr_field_t f);
    return {f.row, f.col};
  endfunction

endpackage

// File: rtl/mlink_bit_timer.sv
// Serial-line front end: 2-FF rx synchronizer, falling-edge detect and
// half-/full-bit tick generation for mid-bit sampling.
// Ports:
//   clk, rst   clock, asynchronous active-low reset
//   rx_i       raw serial line (asynchronous)
//   run_i      timer enable; counter held at 0 while low
//   half_i     select half-bit period (start-bit confirm) instead of full bit
//   rx_s_o     synchronized rx
//   fall_c_o   falling edge on synchronized rx (combinational)
//   tick_c_o   sample strobe (combinational), counter reloads on it
module mlink_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic rx_i,
  input  logic run_i,
  input  logic half_i,
  output logic rx_s_o,
  output logic fall_c_o,
  output logic tick_c_o
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic sync1_q, sync2_q, prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Synchronizer plus one delayed copy for edge detection; idle-high on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rx_s_o   = sync2_q;
  assign fall_c_o = prev_q & ~sync2_q;
  assign tick_c_o = run_i && (cnt_q == (half_i ? HALF_M1 : FULL_M1));

  // Bit timer: 0..period-1, reloads on every sample.
  always_comb begin
    cnt_d = cnt_q;
    if (!run_i || tick_c_o) cnt_d = '0;
    else                    cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/matrix_link_rx.sv
// Receive end of the matrix serial link: deserializes frames and writes each
// good payload into a ROWS x COLS matrix.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   rx                serial line, idles high
//   rd_row, rd_col    read select; r_cell is a combinational read of the matrix
//   r_busy            confirmed start bit through stop-bit sample
//   r_valid / r_err   1-cycle pulses for good / discarded frames
//   r_addr            {row,col} of last good frame
//   frame_cnt         good frames (wraps), err_cnt bad frames (saturates)
module matrix_link_rx
  import matrix_link_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned ROWS         = ROWS_DEF,
  parameter int unsigned COLS         = COLS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  input  logic [ROW_W-1:0]  rd_row,
  input  logic [COL_W-1:0]  rd_col,
  output logic [DATA_W-1:0] r_cell,
  output logic              r_busy,
  output logic              r_valid,
  output logic              r_err,
  output logic [ADDR_W-1:0] r_addr,
  output logic [7:0]        frame_cnt,
  output logic [7:0]        err_cnt
);

  localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic rx_s, fall_c, tick_c;

  rx_state_e state_q, state_d;

  logic [IDX_W-1:0]  idx_q, idx_d;
  addr_field_t       abuf_q, abuf_d;
  logic [DATA_W-1:0] dbuf_q, dbuf_d;
  logic              par_q, par_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        fcnt_q, fcnt_d;
  logic [7:0]        ecnt_q, ecnt_d;
  logic              we_c;

  logic [DATA_W-1:0] mem_q [ROWS][COLS];

  mlink_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .rx_i     (rx),
    .run_i    (state_q != IDLE),
    .half_i   (state_q == START),
    .rx_s_o   (rx_s),
    .fall_c_o (fall_c),
    .tick_c_o (tick_c)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next state; STOP returns to IDLE at the mid-bit sample so gapless frames are caught.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (fall_c) state_d = START;
      START:  if (tick_c) state_d = rx_s ? IDLE : ADDR;
      ADDR:   if (tick_c && idx_q == IDX_W'(ADDR_W - 1)) state_d = DATA;
      DATA:   if (tick_c && idx_q == IDX_W'(DATA_W - 1)) state_d = PARITY;
      PARITY: if (tick_c) state_d = STOP;
      STOP:   if (tick_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and flag next values.
  always_comb begin
    idx_d   = idx_q;
    abuf_d  = abuf_q;
    dbuf_d  = dbuf_q;
    par_d   = par_q;
    busy_d  = busy_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    addr_d  = addr_q;
    fcnt_d  = fcnt_q;
    ecnt_d  = ecnt_q;
    we_c    = 1'b0;
    if (tick_c) begin
      case (state_q)
        START: begin
          if (!rx_s) begin
            busy_d = 1'b1;
            idx_d  = '0;
            par_d  = 1'b0;
          end
        end
        ADDR: begin
          abuf_d = addr_field_t'({rx_s, abuf_q[ADDR_W-1:1]});
          par_d  = par_q ^ rx_s;
          idx_d  = (idx_q == IDX_W'(ADDR_W - 1)) ? '0 : idx_q + IDX_W'(1);
        end
        DATA: begin
          dbuf_d = {rx_s, dbuf_q[DATA_W-1:1]};
          par_d  = par_q ^ rx_s;
          idx_d  = (idx_q == IDX_W'(DATA_W - 1)) ? '0 : idx_q + IDX_W'(1);
        end
        PARITY: par_d = par_q ^ rx_s;
        STOP: begin
          busy_d = 1'b0;
          if (rx_s && par_q == PARITY_RESIDUE) begin
            valid_d = 1'b1;
            we_c    = 1'b1;
            addr_d  = addr_to_rc(abuf_q);
            fcnt_d  = fcnt_q + 8'd1;
          end else begin
            err_d = 1'b1;
            if (ecnt_q != 8'hFF) ecnt_d = ecnt_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q   <= '0;
      abuf_q  <= '0;
      dbuf_q  <= '0;
      par_q   <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      fcnt_q  <= '0;
      ecnt_q  <= '0;
    end else begin
      idx_q   <= idx_d;
      abuf_q  <= abuf_d;
      dbuf_q  <= dbuf_d;
      par_q   <= par_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      fcnt_q  <= fcnt_d;
      ecnt_q  <= ecnt_d;
    end
  end

  // Receive matrix.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      mem_q <= '{default: '0};
    else if (we_c) mem_q[abuf_q.row][abuf_q.col] <= dbuf_q;
  end

  assign r_cell    = mem_q[rd_row][rd_col];
  assign r_busy    = busy_q;
  assign r_valid   = valid_q;
  assign r_err     = err_q;
  assign r_addr    = addr_q;
  assign frame_cnt = fcnt_q;
  assign err_cnt   = ecnt_q;

endmodule

// File: tb/tb_matrix_link_rx.sv
// Bench for matrix_link_rx: serial frame driver, frame-level reference model
// and a scoreboard monitor that checks every r_valid/r_err pulse.
module tb_matrix_link_rx;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx = 1'b1;
  logic       rd_row = 1'b0;
  logic [1:0] rd_col = 2'd0;
  logic [7:0] r_cell;
  logic       r_busy, r_valid, r_err;
  logic [2:0] r_addr;
  logic [7:0] frame_cnt, err_cnt;

  matrix_link_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rd_row    (rd_row),
    .rd_col    (rd_col),
    .r_cell    (r_cell),
    .r_busy    (r_busy),
    .r_valid   (r_valid),
    .r_err     (r_err),
    .r_addr    (r_addr),
    .frame_cnt (frame_cnt),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       is_err;
    bit [2:0] addr;
    bit [7:0] fc;
    bit [7:0] ec;
  } exp_t;

  exp_t     exp_q[$];
  bit [7:0] mem_m [2][4];
  int       fc_m = 0;
  int       ec_m = 0;
  int       n_checks = 0;
  int       n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 4; c++) mem_m[r][c] = 8'h00;
    fc_m = 0;
    ec_m = 0;
  endtask

  // Scoreboard monitor: every pulse must match the oldest expected frame outcome.
  always @(negedge clk) begin
    exp_t e;
    if (rst && (r_valid || r_err)) begin
      chk("flag_exclusive", 32'(r_valid & r_err), 32'd0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pulse: got valid=%0b err=%0b expected none (t=%0t)",
                 r_valid, r_err, $time);
      end else begin
        e = exp_q.pop_front();
        chk("pulse_kind_err", 32'(r_err), 32'(e.is_err));
        if (!e.is_err) chk("r_addr", 32'(r_addr), 32'(e.addr));
        chk("frame_cnt", 32'(frame_cnt), 32'(e.fc));
        chk("err_cnt", 32'(err_cnt), 32'(e.ec));
      end
    end
  end

  task automatic idle_bits(input int n);
    rx = 1'b1;
    repeat (n * CPB) @(posedge clk);
  endtask

  task automatic do_reset();
    #2 rst = 1'b0;
    rx = 1'b1;
    model_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(r_busy), 32'd0);
    chk("rst_valid", 32'(r_valid), 32'd0);
    chk("rst_err", 32'(r_err), 32'd0);
    chk("rst_fcnt", 32'(frame_cnt), 32'd0);
    chk("rst_ecnt", 32'(err_cnt), 32'd0);
    chk("rst_addr", 32'(r_addr), 32'd0);
    rst = 1'b1;
    chk("rst_queue_empty", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // Drive one frame; abort_at=8 resets the DUT mid data bit 4.
  task automatic send_frame(input bit row, input bit [1:0] col, input bit [7:0] data,
                            input bit flip_par, input bit stop_v, input int abort_at);
    bit   b[14];
    bit   good;
    exp_t e;
    b[0] = 1'b0;
    b[1] = row;
    b[2] = col[0];
    b[3] = col[1];
    for (int i = 0; i < 8; i++) b[4+i] = data[i];
    b[12] = (^{row, col, data}) ^ flip_par;
    b[13] = stop_v;
    if (abort_at < 0) begin
      good = !flip_par && stop_v;
      if (good) begin
        mem_m[row][col] = data;
        fc_m = (fc_m + 1) % 256;
      end else if (ec_m < 255) begin
        ec_m = ec_m + 1;
      end
      e.is_err = !good;
      e.addr   = {row, col};
      e.fc     = 8'(fc_m);
      e.ec     = 8'(ec_m);
      exp_q.push_back(e);
    end
    for (int k = 0; k < 14; k++) begin
      rx = b[k];
      if (k == 8) begin
        repeat (CPB / 2) @(posedge clk);
        @(negedge clk);
        chk("busy_mid_frame", 32'(r_busy), 32'd1);
        if (abort_at == 8) begin
          do_reset();
          return;
        end
        repeat (CPB / 2) @(posedge clk);
      end else begin
        repeat (CPB) @(posedge clk);
      end
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 4 * CPB && exp_q.size() != 0; i++) @(posedge clk);
    chk("outcomes_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic check_mem(input string tag);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 4; c++) begin
        rd_row = 1'(r);
        rd_col = 2'(c);
        @(negedge clk);
        chk(tag, 32'(r_cell), 32'(mem_m[r][c]));
      end
  endtask

  task automatic check_counts(input string tag);
    @(negedge clk);
    chk({tag, "_fcnt"}, 32'(frame_cnt), 32'(fc_m));
    chk({tag, "_ecnt"}, 32'(err_cnt), 32'(ec_m));
  endtask

  initial begin
    int busy_seen;
    bit row, flip, stopv;
    bit [1:0] col;
    bit [7:0] data;
    int gap;

    model_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", 32'(r_busy), 32'd0);
    chk("reset_cell", 32'(r_cell), 32'd0);
    chk("reset_fcnt", 32'(frame_cnt), 32'd0);
    rst = 1'b1;
    idle_bits(2);

    // Single good frame.
    send_frame(1'b0, 2'd1, 8'h22, 1'b0, 1'b1, -1);
    idle_bits(2);
    wait_drain();
    check_mem("s1_cell");
    check_counts("s1");

    // Parity flipped.
    send_frame(1'b0, 2'd2, 8'h33, 1'b1, 1'b1, -1);
    idle_bits(2);
    wait_drain();
    check_mem("s2_cell");
    check_counts("s2");

    // Eight gapless frames, row-major.
    for (int i = 0; i < 8; i++)
      send_frame(1'(i / 4), 2'(i % 4), 8'(8'h11 * (i + 1)), 1'b0, 1'b1, -1);
    idle_bits(2);
    wait_drain();
    check_mem("s3_cell");
    check_counts("s3");

    // Short glitch must not start a frame.
    rx = 1'b0;
    repeat (3) @(posedge clk);
    rx = 1'b1;
    busy_seen = 0;
    for (int i = 0; i < 2 * CPB; i++) begin
      @(negedge clk);
      if (r_busy) busy_seen++;
    end
    chk("glitch_busy_cycles", 32'(busy_seen), 32'd0);
    check_counts("s4");

    // Stop bit low, then line break.
    send_frame(1'b1, 2'd0, 8'h55, 1'b0, 1'b0, -1);
    rx = 1'b0;
    busy_seen = 0;
    for (int i = 0; i < 5 * CPB; i++) begin
      @(negedge clk);
      if (r_busy) busy_seen++;
    end
    chk("break_busy_cycles", 32'(busy_seen), 32'd0);
    idle_bits(2);
    wait_drain();
    check_mem("s5_cell");
    check_counts("s5");
    send_frame(1'b1, 2'd0, 8'h5A, 1'b0, 1'b1, -1);
    idle_bits(2);
    wait_drain();
    check_mem("s5b_cell");

    // Reset during data bit 4, then a clean frame.
    send_frame(1'b0, 2'd3, 8'h77, 1'b0, 1'b1, 8);
    idle_bits(2);
    check_mem("s6_cleared");
    check_counts("s6");
    send_frame(1'b1, 2'd3, 8'hA5, 1'b0, 1'b1, -1);
    idle_bits(2);
    wait_drain();
    check_mem("s6_cell");
    check_counts("s6b");

    // Random traffic with occasional parity/stop errors and gapless runs.
    for (int n = 0; n < 24; n++) begin
      row   = 1'($urandom_range(0, 1));
      col   = 2'($urandom_range(0, 3));
      data  = 8'($urandom_range(0, 255));
      flip  = ($urandom_range(0, 4) == 0);
      stopv = ($urandom_range(0, 9) != 0);
      gap   = $urandom_range(0, 2);
      if (!stopv && gap == 0) gap = 1;
      send_frame(row, col, data, flip, stopv, -1);
      if (gap > 0) idle_bits(gap);
    end
    idle_bits(2);
    wait_drain();
    check_mem("rand_cell");
    check_counts("rand");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion expected finish before timeout");
    $fatal(1, "watchdog");
  end

endmodule
